fpga_array: RTL and testbench



---
 rtl/fpga_pkg.sv | 14 +
 rtl/fpga_cfg_if.sv | 28 ++
 rtl/fpga_cfg_loader.sv | 106 ++++++++++
 rtl/fpgacell.sv | 59 +++++
 rtl/fpga_array.sv | 118 +++++++++++
 tb/tb_fpga_array.sv | 396 +++++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/fpga_pkg.sv
// fpga_pkg: shared constants and types for the fabric top and its loader.
// Exports CFG_WORD_W and the loader state enum cfg_state_t.
package fpga_pkg;

  localparam int CFG_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } cfg_state_t;

endpackage

// File: rtl/fpga_cfg_if.sv
// fpga_cfg_if: configuration word port plus readback stream.
// master drives start/word/valid; slave returns ready/busy/done/err/rb_*.
interface fpga_cfg_if;
  import fpga_pkg::*;

  logic                  cfg_start;
  logic [CFG_WORD_W-1:0] cfg_word;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic                  cfg_busy;
  logic                  cfg_done;
  logic                  cfg_err;
  logic [CFG_WORD_W-1:0] rb_word;
  logic                  rb_valid;

  modport master (
    output cfg_start, cfg_word, cfg_valid,
    input  cfg_ready, cfg_busy, cfg_done, cfg_err,
    input  rb_word, rb_valid
  );

  modport slave (
    input  cfg_start, cfg_word, cfg_valid,
    output cfg_ready, cfg_busy, cfg_done, cfg_err,
    output rb_word, rb_valid
  );

endinterface

// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: accepts 32-bit words, shifts them MSB-first into the
// CRAM chain, and packs the chain output into readback words.
module fpga_cfg_loader
  import fpga_pkg::*;
#(
  parameter int TOTAL = 256
) (
  input  logic       clk,
  input  logic       rst,
  fpga_cfg_if.slave  cfg,
  output logic       config_en_o,
  output logic       chain_o,
  input  logic       chain_i
);

  localparam int CW = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] TOT = CW'(TOTAL);

  cfg_state_t            state_q;
  logic [CFG_WORD_W-1:0] sh_q;
  logic [CFG_WORD_W-1:0] rb_q;
  logic [CFG_WORD_W-1:0] rb_word_q;
  logic                  rb_valid_q;
  logic [4:0]            bit_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic [CFG_WORD_W-1:0] rb_d;
  logic                  done_q;
  logic                  err_q;

  assign cnt_d = cnt_q + 1'b1;
  assign rb_d  = {rb_q[CFG_WORD_W-2:0], chain_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      rb_q       <= '0;
      rb_word_q  <= '0;
      rb_valid_q <= 1'b0;
      bit_q      <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rb_valid_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (cfg.cfg_start) begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          // Restart beats a word offered in the same cycle
          if (cfg.cfg_start) begin
            err_q   <= 1'b1;
            cnt_q   <= '0;
            sh_q    <= '0;
            bit_q   <= '0;
          end else if (cfg.cfg_valid) begin
            sh_q    <= cfg.cfg_word;
            bit_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (cfg.cfg_start) begin
            err_q   <= 1'b1;
            cnt_q   <= '0;
            sh_q    <= '0;
            bit_q   <= '0;
            state_q <= LOAD;
          end else begin
            sh_q  <= {sh_q[CFG_WORD_W-2:0], 1'b0};
            rb_q  <= rb_d;
            cnt_q <= cnt_d;
            bit_q <= bit_q + 1'b1;
            if (bit_q == 5'd31) begin
              rb_word_q  <= rb_d;
              rb_valid_q <= 1'b1;
              if (cnt_d == TOT) begin
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                state_q <= LOAD;
              end
            end
          end
        end
      endcase
    end
  end

  assign cfg.cfg_ready = (state_q == LOAD);
  assign cfg.cfg_busy  = (state_q == LOAD) || (state_q == SHIFT);
  assign cfg.cfg_done  = done_q;
  assign cfg.cfg_err   = err_q;
  assign cfg.rb_word   = rb_word_q;
  assign cfg.rb_valid  = rb_valid_q;
  assign config_en_o   = (state_q == SHIFT);
  assign chain_o       = sh_q[CFG_WORD_W-1];

endmodule

// File: rtl/fpgacell.sv
// fpgacell: one fabric tile. CRAM is a serial shift chain (config_in ->
// config_out); cram[2d+1:2d] picks the source bus for registered output d.
module fpgacell #(
  parameter int BUS_WIDTH = 16,
  parameter int CFG_BITS  = 1024
) (
  input  logic                 config_clk,
  input  logic                 nrst,
  input  logic                 config_en,
  input  logic                 config_in,
  output logic                 config_out,
  input  logic                 le_clk,
  input  logic                 le_en,
  input  logic                 le_nrst,
  input  logic [BUS_WIDTH-1:0] CBnorth_in,
  input  logic [BUS_WIDTH-1:0] SBsouth_in,
  input  logic [BUS_WIDTH-1:0] CBeast_in,
  input  logic [BUS_WIDTH-1:0] SBwest_in,
  output logic [BUS_WIDTH-1:0] CBnorth_out,
  output logic [BUS_WIDTH-1:0] SBsouth_out,
  output logic [BUS_WIDTH-1:0] CBeast_out,
  output logic [BUS_WIDTH-1:0] SBwest_out
);

  logic [CFG_BITS-1:0]           cram_q;
  logic [3:0][BUS_WIDTH-1:0]     bus_in;
  logic [3:0][BUS_WIDTH-1:0]     bus_q;
  logic                          unused_cram;

  always_ff @(posedge config_clk or negedge nrst) begin
    if (!nrst) begin
      cram_q <= '0;
    end else if (config_en) begin
      cram_q <= {cram_q[CFG_BITS-2:0], config_in};
    end
  end

  assign config_out  = cram_q[CFG_BITS-1];
  assign unused_cram = ^cram_q[CFG_BITS-2:8];

  // Source index: 0=north 1=south 2=east 3=west
  assign bus_in = {SBwest_in, CBeast_in, SBsouth_in, CBnorth_in};

  always_ff @(posedge le_clk or negedge le_nrst) begin
    if (!le_nrst) begin
      bus_q <= '0;
    end else if (le_en) begin
      for (int d = 0; d < 4; d++) begin
        bus_q[d] <= bus_in[cram_q[2*d +: 2]];
      end
    end
  end

  assign CBnorth_out = bus_q[0];
  assign SBsouth_out = bus_q[1];
  assign CBeast_out  = bus_q[2];
  assign SBwest_out  = bus_q[3];

endmodule

// File: rtl/fpga_array.sv
// fpga_array: ROWSxCOLS mesh of fpgacell tiles with edge I/O, one CRAM
// chain fed by the loader; fabric held off until cfg_done.
module fpga_array
  import fpga_pkg::*;
#(
  parameter int BUS_WIDTH     = 16,
  parameter int ROWS          = 2,
  parameter int COLS          = 2,
  parameter int CELL_CFG_BITS = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  fpga_cfg_if.slave                 cfg,
  input  logic                      le_clk,
  input  logic                      le_en,
  input  logic                      le_nrst,
  input  logic [BUS_WIDTH*COLS-1:0] io_north_in,
  output logic [BUS_WIDTH*COLS-1:0] io_north_out,
  input  logic [BUS_WIDTH*COLS-1:0] io_south_in,
  output logic [BUS_WIDTH*COLS-1:0] io_south_out,
  input  logic [BUS_WIDTH*ROWS-1:0] io_east_in,
  output logic [BUS_WIDTH*ROWS-1:0] io_east_out,
  input  logic [BUS_WIDTH*ROWS-1:0] io_west_in,
  output logic [BUS_WIDTH*ROWS-1:0] io_west_out
);

  localparam int NC    = ROWS * COLS;
  localparam int TOTAL = NC * CELL_CFG_BITS;
  localparam int BW    = BUS_WIDTH;

  if (TOTAL % CFG_WORD_W != 0) begin : g_bad_total
    $error("fpga_array: total CRAM bits not a multiple of 32");
  end

  logic          config_en;
  logic          fab_en;
  logic          fab_nrst;
  logic [NC:0]   chain;
  logic [BW-1:0] n_in  [NC];
  logic [BW-1:0] n_out [NC];
  logic [BW-1:0] s_in  [NC];
  logic [BW-1:0] s_out [NC];
  logic [BW-1:0] e_in  [NC];
  logic [BW-1:0] e_out [NC];
  logic [BW-1:0] w_in  [NC];
  logic [BW-1:0] w_out [NC];

  assign fab_en   = le_en & cfg.cfg_done;
  assign fab_nrst = le_nrst & cfg.cfg_done;

  fpga_cfg_loader #(
    .TOTAL(TOTAL)
  ) u_loader (
    .clk        (clk),
    .rst        (rst),
    .cfg        (cfg),
    .config_en_o(config_en),
    .chain_o    (chain[0]),
    .chain_i    (chain[NC])
  );

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int K = r * COLS + c;

      if (r == ROWS - 1) begin : g_n_edge
        assign n_in[K] = io_north_in[c*BW +: BW];
        assign io_north_out[c*BW +: BW] = n_out[K];
      end else begin : g_n_mesh
        assign n_in[K] = s_out[K+COLS];
      end

      if (r == 0) begin : g_s_edge
        assign s_in[K] = io_south_in[c*BW +: BW];
        assign io_south_out[c*BW +: BW] = s_out[K];
      end else begin : g_s_mesh
        assign s_in[K] = n_out[K-COLS];
      end

      if (c == COLS - 1) begin : g_e_edge
        assign e_in[K] = io_east_in[r*BW +: BW];
        assign io_east_out[r*BW +: BW] = e_out[K];
      end else begin : g_e_mesh
        assign e_in[K] = w_out[K+1];
      end

      if (c == 0) begin : g_w_edge
        assign w_in[K] = io_west_in[r*BW +: BW];
        assign io_west_out[r*BW +: BW] = w_out[K];
      end else begin : g_w_mesh
        assign w_in[K] = e_out[K-1];
      end

      fpgacell #(
        .BUS_WIDTH(BW),
        .CFG_BITS (CELL_CFG_BITS)
      ) u_cell (
        .config_clk (clk),
        .nrst       (~rst),
        .config_en  (config_en),
        .config_in  (chain[K]),
        .config_out (chain[K+1]),
        .le_clk     (le_clk),
        .le_en      (fab_en),
        .le_nrst    (fab_nrst),
        .CBnorth_in (n_in[K]),
        .SBsouth_in (s_in[K]),
        .CBeast_in  (e_in[K]),
        .SBwest_in  (w_in[K]),
        .CBnorth_out(n_out[K]),
        .SBsouth_out(s_out[K]),
        .CBeast_out (e_out[K]),
        .SBwest_out (w_out[K])
      );
    end
  end

endmodule

// File: tb/tb_fpga_array.sv
// tb_fpga_array: randomized bench for fpga_array, 2x2 cells x 64 CRAM bits.
// Readback is checked against a bit-level FIFO model of the whole chain.
module tb_fpga_array;
  import fpga_pkg::*;

  localparam int BW    = 8;
  localparam int R     = 2;
  localparam int C     = 2;
  localparam int NB    = 64;
  localparam int NC    = R * C;
  localparam int TOTAL = NC * NB;
  localparam int NW    = TOTAL / 32;

  logic clk = 0;
  logic le_clk = 0;
  logic rst = 1;
  logic le_en = 0;
  logic le_nrst = 0;
  logic [BW*C-1:0] io_n_in = '0;
  logic [BW*C-1:0] io_n_out;
  logic [BW*C-1:0] io_s_in = '0;
  logic [BW*C-1:0] io_s_out;
  logic [BW*R-1:0] io_e_in = '0;
  logic [BW*R-1:0] io_e_out;
  logic [BW*R-1:0] io_w_in = '0;
  logic [BW*R-1:0] io_w_out;

  fpga_cfg_if cfg ();

  fpga_array #(
    .BUS_WIDTH    (BW),
    .ROWS         (R),
    .COLS         (C),
    .CELL_CFG_BITS(NB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg         (cfg),
    .le_clk      (le_clk),
    .le_en       (le_en),
    .le_nrst     (le_nrst),
    .io_north_in (io_n_in),
    .io_north_out(io_n_out),
    .io_south_in (io_s_in),
    .io_south_out(io_s_out),
    .io_east_in  (io_e_in),
    .io_east_out (io_e_out),
    .io_west_in  (io_w_in),
    .io_west_out (io_w_out)
  );

  always #5 clk = ~clk;
  always #7 le_clk = ~le_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int en_cnt = 0;
  logic [31:0] rb_act[$];
  logic [31:0] rb_exp[$];
  logic        fifo[$];

  always @(negedge clk) begin
    if (dut.config_en === 1'b1) en_cnt++;
    if (cfg.rb_valid === 1'b1) rb_act.push_back(cfg.rb_word);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  // Chain model: TOTAL-bit FIFO, unknown after reset
  task automatic model_reset();
    fifo.delete();
    repeat (TOTAL) fifo.push_back(1'bx);
    rb_exp.delete();
  endtask

  task automatic model_word(input logic [31:0] w);
    logic [31:0] e;
    e = '0;
    for (int b = 31; b >= 0; b--) begin
      e = {e[30:0], fifo.pop_front()};
      fifo.push_back(w[b]);
    end
    rb_exp.push_back(e);
  endtask

  task automatic do_start();
    @(negedge clk);
    cfg.cfg_start = 1'b1;
    @(negedge clk);
    cfg.cfg_start = 1'b0;
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 100 && cfg.cfg_ready !== 1'b1; n++) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    @(negedge clk);
    wait_ready();
    if (cfg.cfg_ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_word: ready=%b required 1", cfg.cfg_ready);
    end else begin
      cfg.cfg_word  = w;
      cfg.cfg_valid = 1'b1;
      model_word(w);
      @(negedge clk);
      cfg.cfg_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    for (int n = 0; n < 200 && cfg.cfg_done !== 1'b1; n++) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({cfg.cfg_ready, cfg.cfg_busy, cfg.cfg_done, cfg.cfg_err,
         cfg.rb_valid, dut.config_en} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b required 000000",
        {cfg.cfg_ready, cfg.cfg_busy, cfg.cfg_done, cfg.cfg_err,
         cfg.rb_valid, dut.config_en});
    end
    n_cmp++;
    if (cfg.rb_word !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_rb_word: got %h required 0", cfg.rb_word);
    end
    n_cmp++;
    if (dut.fab_en !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_fab_en: got %b required 0", dut.fab_en);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load();
    model_reset();
    do_start();
    #1;
    n_cmp++;
    if ({cfg.cfg_ready, cfg.cfg_busy} !== 2'b11) begin
      n_bad++;
      $display("FAIL load_enter: ready,busy=%b required 11",
        {cfg.cfg_ready, cfg.cfg_busy});
    end
    en_cnt = 0;
    rb_act.delete();
    for (int i = 0; i < NW; i++) send_word(32'hA5A5_0000 + 32'(i));
    repeat (31) @(negedge clk);
    #1;
    n_cmp++;
    if ({cfg.cfg_done, dut.config_en, cfg.rb_valid} !== 3'b010) begin
      n_bad++;
      $display("FAIL load_t32: done,en,rbv=%b required 010",
        {cfg.cfg_done, dut.config_en, cfg.rb_valid});
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({cfg.cfg_done, dut.config_en, cfg.rb_valid, cfg.cfg_busy} !== 4'b1010) begin
      n_bad++;
      $display("FAIL load_t33: done,en,rbv,busy=%b required 1010",
        {cfg.cfg_done, dut.config_en, cfg.rb_valid, cfg.cfg_busy});
    end
    n_cmp++;
    if (en_cnt !== TOTAL) begin
      n_bad++;
      $display("FAIL load_en_cycles: got %0d required %0d", en_cnt, TOTAL);
    end
    n_cmp++;
    if (rb_act.size() !== NW) begin
      n_bad++;
      $display("FAIL load_rb_count: got %0d required %0d", rb_act.size(), NW);
    end
  endtask

  task automatic test_readback();
    rb_act.delete();
    rb_exp.delete();
    do_start();
    for (int i = 0; i < NW; i++) send_word(32'h1234_5678);
    wait_done();
    n_cmp++;
    if ({cfg.cfg_done, cfg.cfg_err} !== 2'b10) begin
      n_bad++;
      $display("FAIL rb_done: done,err=%b required 10",
        {cfg.cfg_done, cfg.cfg_err});
    end
    n_cmp++;
    if (rb_act.size() !== rb_exp.size()) begin
      n_bad++;
      $display("FAIL rb_count: got %0d required %0d", rb_act.size(), rb_exp.size());
    end
    for (int i = 0; i < rb_exp.size() && i < rb_act.size(); i++) begin
      if (!$isunknown(rb_exp[i])) begin
        n_cmp++;
        if (rb_act[i] !== rb_exp[i]) begin
          n_bad++;
          $display("FAIL rb_word[%0d]: got %h required %h", i, rb_act[i], rb_exp[i]);
        end
      end
    end
  endtask

  task automatic test_restart();
    logic [31:0] w;
    rb_act.delete();
    rb_exp.delete();
    do_start();
    for (int i = 0; i < 3; i++) send_word($urandom);
    @(negedge clk);
    wait_ready();
    cfg.cfg_start = 1'b1;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_word  = $urandom;
    @(negedge clk);
    cfg.cfg_start = 1'b0;
    cfg.cfg_valid = 1'b0;
    #1;
    n_cmp++;
    if ({cfg.cfg_err, cfg.cfg_ready, dut.config_en, cfg.cfg_done} !== 4'b1100) begin
      n_bad++;
      $display("FAIL restart_state: err,ready,en,done=%b required 1100",
        {cfg.cfg_err, cfg.cfg_ready, dut.config_en, cfg.cfg_done});
    end
    for (int i = 0; i < NW - 1; i++) begin
      w = $urandom;
      send_word(w);
    end
    repeat (40) @(negedge clk);
    #1;
    n_cmp++;
    if ({cfg.cfg_done, cfg.cfg_busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL restart_7words: done,busy=%b required 01",
        {cfg.cfg_done, cfg.cfg_busy});
    end
    send_word($urandom);
    wait_done();
    n_cmp++;
    if ({cfg.cfg_done, cfg.cfg_err} !== 2'b11) begin
      n_bad++;
      $display("FAIL restart_8words: done,err=%b required 11",
        {cfg.cfg_done, cfg.cfg_err});
    end
    n_cmp++;
    if (rb_act.size() !== rb_exp.size()) begin
      n_bad++;
      $display("FAIL restart_rb_count: got %0d required %0d", rb_act.size(), rb_exp.size());
    end
    for (int i = 0; i < rb_exp.size() && i < rb_act.size(); i++) begin
      if (!$isunknown(rb_exp[i])) begin
        n_cmp++;
        if (rb_act[i] !== rb_exp[i]) begin
          n_bad++;
          $display("FAIL restart_rb[%0d]: got %h required %h", i, rb_act[i], rb_exp[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    rb_act.delete();
    rb_exp.delete();
    do_start();
    en_cnt = 0;
    repeat (10) @(negedge clk);
    #1;
    n_cmp++;
    if (en_cnt !== 0 || cfg.cfg_ready !== 1'b1 || cfg.cfg_err !== 1'b0) begin
      n_bad++;
      $display("FAIL stall: en_cnt=%0d ready=%b err=%b required 0 1 0",
        en_cnt, cfg.cfg_ready, cfg.cfg_err);
    end
    for (int i = 0; i < NW; i++) send_word($urandom);
    wait_done();
    n_cmp++;
    if (cfg.cfg_done !== 1'b1 || en_cnt !== TOTAL) begin
      n_bad++;
      $display("FAIL stall_done: done=%b en_cnt=%0d required 1 %0d",
        cfg.cfg_done, en_cnt, TOTAL);
    end
    for (int i = 0; i < rb_exp.size() && i < rb_act.size(); i++) begin
      if (!$isunknown(rb_exp[i])) begin
        n_cmp++;
        if (rb_act[i] !== rb_exp[i]) begin
          n_bad++;
          $display("FAIL stall_rb[%0d]: got %h required %h", i, rb_act[i], rb_exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_start();
    send_word($urandom);
    repeat (5) @(negedge clk);
    le_en   = 1'b1;
    le_nrst = 1'b1;
    #1;
    n_cmp++;
    if (dut.config_en !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_pre: config_en=%b required 1", dut.config_en);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({cfg.cfg_ready, cfg.cfg_busy, cfg.cfg_done, cfg.cfg_err,
         cfg.rb_valid, dut.config_en} !== 6'b0 || cfg.rb_word !== 32'h0) begin
      n_bad++;
      $display("FAIL midrst_outputs: flags=%b rb=%h required 000000 0",
        {cfg.cfg_ready, cfg.cfg_busy, cfg.cfg_done, cfg.cfg_err,
         cfg.rb_valid, dut.config_en}, cfg.rb_word);
    end
    n_cmp++;
    if ({dut.fab_en, dut.fab_nrst} !== 2'b00) begin
      n_bad++;
      $display("FAIL midrst_gate: fab_en,fab_nrst=%b required 00",
        {dut.fab_en, dut.fab_nrst});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    rb_act.delete();
  endtask

  task automatic test_route();
    logic [NB-1:0] want[NC];
    logic [31:0]   w;
    logic [BW*R-1:0] exp_e;
    int p;
    for (int k = 0; k < NC; k++) want[k] = '0;
    // East output of cells 0 and 1 takes the west input (select 3)
    want[0][5:4] = 2'b11;
    want[1][5:4] = 2'b11;
    do_start();
    for (int wi = 0; wi < NW; wi++) begin
      for (int b = 0; b < 32; b++) begin
        p = TOTAL - 1 - (wi * 32 + b);
        w[31-b] = want[p / NB][p % NB];
      end
      send_word(w);
    end
    wait_done();
    n_cmp++;
    if ({cfg.cfg_done, dut.fab_en, dut.fab_nrst} !== 3'b111) begin
      n_bad++;
      $display("FAIL route_gate: done,fab_en,fab_nrst=%b required 111",
        {cfg.cfg_done, dut.fab_en, dut.fab_nrst});
    end
    for (int it = 0; it < 3; it++) begin
      io_w_in = BW*R'($urandom);
      io_n_in = BW*C'($urandom);
      io_e_in = BW*R'($urandom);
      io_s_in = BW*C'($urandom);
      repeat (4) @(negedge le_clk);
      #1;
      // Row 0: west in -> cell0 -> cell1 -> east out
      // Row 1: cell3 east selects its north input (top edge, column 1)
      exp_e = {io_n_in[BW +: BW], io_w_in[0 +: BW]};
      n_cmp++;
      if (io_e_out !== exp_e) begin
        n_bad++;
        $display("FAIL route_east[%0d]: got %h required %h", it, io_e_out, exp_e);
      end
    end
  endtask

  initial begin
    cfg.cfg_start = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_word  = '0;
    test_reset();
    test_load();
    test_readback();
    test_restart();
    test_stall();
    test_reset_mid();
    test_route();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
